// File: rtl/microsequencer.sv
// Microsequencer: next-state controller for the microprogrammed MIPS control
// unit. Holds the current microstate, a single-level return register and two
// sticky error flags. The next state is chosen by the microinstruction's
// n_sel mode from opcode dispatch, a selected condition, the branch target cr
// or the return register.
// Optional feature: define MICROSEQ_TIMEOUT_EN to bound wait mode (101) with
// a 4-bit counter. Once the counter reaches TIMEOUT, the next state is
// ILLEGAL_STATE and the timeout flag is set.
// Handshake: there is no valid/ready pair. mfc is level-sampled every rising
// edge, and wait mode advances on the first edge where the selected condition
// is true.
module microsequencer #(
  parameter int STATE_W       = 7,
  parameter int RESET_STATE   = 0,
  parameter int ILLEGAL_STATE = 5,
  parameter int TIMEOUT       = 15
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [5:0]         opcode,
  input  logic               mfc,
  input  logic               zero,
  input  logic               neg,
  input  logic [2:0]         n_sel,
  input  logic               inv,
  input  logic [1:0]         s_sel,
  input  logic [STATE_W-1:0] cr,
  output logic [STATE_W-1:0] state,
  output logic               illegal_op,
  output logic               timeout
);

  localparam logic [2:0] MODE_DISPATCH  = 3'b000;
  localparam logic [2:0] MODE_JUMP      = 3'b001;
  localparam logic [2:0] MODE_INC       = 3'b010;
  localparam logic [2:0] MODE_BRANCH    = 3'b011;
  localparam logic [2:0] MODE_CDISPATCH = 3'b100;
  localparam logic [2:0] MODE_WAIT      = 3'b101;
  localparam logic [2:0] MODE_CALL      = 3'b110;
  localparam logic [2:0] MODE_RETURN    = 3'b111;

  localparam logic [STATE_W-1:0] RST_S = STATE_W'(RESET_STATE);
  localparam logic [STATE_W-1:0] ILL_S = STATE_W'(ILLEGAL_STATE);

  logic [STATE_W-1:0] ret;
  logic [STATE_W-1:0] inc;
  logic [STATE_W-1:0] enc;
  logic               enc_ok;
  logic               cond;
  logic [STATE_W-1:0] next_state;
  logic               load_ret;
  logic               set_ill;
  logic               wait_hold;

  assign inc = state + 1'b1;

  // Condition select with optional inversion.
  always_comb begin
    cond = 1'b1;
    case (s_sel)
      2'b00:   cond = mfc;
      2'b01:   cond = zero;
      2'b10:   cond = neg;
      default: cond = 1'b1;
    endcase
    cond = cond ^ inv;
  end

  // Opcode dispatch ROM; unknown opcodes land on the illegal-op handler.
  always_comb begin
    enc    = ILL_S;
    enc_ok = 1'b1;
    case (opcode)
      6'b000000: enc = STATE_W'(6);
      6'b100011: enc = STATE_W'(7);
      6'b101011: enc = STATE_W'(9);
      6'b000100: enc = STATE_W'(11);
      6'b001000: enc = STATE_W'(12);
      default:   enc_ok = 1'b0;
    endcase
  end

  // Next-state selection by next-address mode.
  always_comb begin
    next_state = state;
    load_ret   = 1'b0;
    set_ill    = 1'b0;
    wait_hold  = 1'b0;
    case (n_sel)
      MODE_DISPATCH: begin
        next_state = enc;
        set_ill    = !enc_ok;
      end
      MODE_JUMP:   next_state = cr;
      MODE_INC:    next_state = inc;
      MODE_BRANCH: next_state = cond ? cr : inc;
      MODE_CDISPATCH: begin
        next_state = cond ? cr : enc;
        set_ill    = !cond && !enc_ok;
      end
      MODE_WAIT: begin
        next_state = cond ? inc : state;
        wait_hold  = !cond;
      end
      MODE_CALL: begin
        next_state = cr;
        load_ret   = 1'b1;
      end
      default: next_state = ret;
    endcase
  end

`ifdef MICROSEQ_TIMEOUT_EN
  logic [3:0] wait_cnt;
  logic       to_fire;
  logic       timeout_q;

  assign to_fire = wait_hold && (wait_cnt == 4'(TIMEOUT));
  assign timeout = timeout_q;

  // Wait counter: counts held wait cycles, clears on any other cycle or on expiry.
  always_ff @(posedge clk) begin
    if (!reset) begin
      wait_cnt  <= 4'd0;
      timeout_q <= 1'b0;
    end else if (to_fire) begin
      wait_cnt  <= 4'd0;
      timeout_q <= 1'b1;
    end else if (wait_hold) begin
      wait_cnt  <= wait_cnt + 4'd1;
    end else begin
      wait_cnt  <= 4'd0;
    end
  end
`else
  logic to_fire;
  assign to_fire = 1'b0;
  assign timeout = 1'b0;
`endif

  // Microstate, return register and sticky illegal-opcode flag.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state      <= RST_S;
      ret        <= '0;
      illegal_op <= 1'b0;
    end else begin
      state <= to_fire ? ILL_S : next_state;
      if (load_ret) ret <= inc;
      if (set_ill) illegal_op <= 1'b1;
    end
  end

endmodule

// File: tb/tb_microsequencer.sv
// Testbench for microsequencer. Directed scenarios first, then randomized
// microinstructions. A reference model predicts each edge's result and pushes
// it into exp_q. A monitor pops one entry after every edge and compares it.
module tb_microsequencer;

  localparam int W = 9; // {state[6:0], illegal_op, timeout}

  logic       clk = 1'b0;
  logic       reset;
  logic [5:0] opcode;
  logic       mfc, zero, neg, inv;
  logic [2:0] n_sel;
  logic [1:0] s_sel;
  logic [6:0] cr;
  logic [6:0] state;
  logic       illegal_op, timeout;

  logic [W-1:0] exp_q[$];
  int checks = 0;
  int errors = 0;
  string phase = "init";

  // Reference model state
  int  m_state = 0;
  int  m_ret = 0;
  bit  m_ill = 0;
  bit  m_to = 0;
  int  m_wcnt = 0;
  int  legal_ops[5] = '{0, 35, 43, 4, 8};
  int  legal_tgt[5] = '{6, 7, 9, 11, 12};

  microsequencer dut (
    .clk(clk), .reset(reset), .opcode(opcode), .mfc(mfc), .zero(zero),
    .neg(neg), .n_sel(n_sel), .inv(inv), .s_sel(s_sel), .cr(cr),
    .state(state), .illegal_op(illegal_op), .timeout(timeout)
  );

  // Clock
  always #5 clk = ~clk;

  // Watchdog
  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $display("Result: errors=%0d of %0d checks", errors + 1, checks + 1);
    $fatal(1, "watchdog");
  end

  // Opcode table lookup: returns target or -1 for unknown.
  function automatic int decode(input int op);
    for (int i = 0; i < 5; i++)
      if (legal_ops[i] == op) return legal_tgt[i];
    return -1;
  endfunction

  // Advance the model by one edge for the given inputs.
  task automatic model_edge(input bit rst, input int mode, input bit iv,
                            input int ss, input int tgt, input int op,
                            input bit m, input bit z, input bit n);
    bit cv;
    int nxt, d, incv;
    bit hold;
    if (!rst) begin
      m_state = 0; m_ret = 0; m_ill = 0; m_to = 0; m_wcnt = 0;
      return;
    end
    case (ss)
      0: cv = m;
      1: cv = z;
      2: cv = n;
      default: cv = 1;
    endcase
    cv = cv ^ iv;
    incv = (m_state + 1) % 128;
    hold = 0;
    nxt = m_state;
    d = decode(op);
    case (mode)
      0: nxt = (d < 0) ? 5 : d;
      1: nxt = tgt;
      2: nxt = incv;
      3: nxt = cv ? tgt : incv;
      4: nxt = cv ? tgt : ((d < 0) ? 5 : d);
      5: begin
        if (cv) nxt = incv;
        else hold = 1;
      end
      6: begin m_ret = incv; nxt = tgt; end
      default: nxt = m_ret;
    endcase
    if ((mode == 0 && d < 0) || (mode == 4 && !cv && d < 0)) m_ill = 1;
`ifdef MICROSEQ_TIMEOUT_EN
    if (hold) begin
      if (m_wcnt == 15) begin nxt = 5; m_to = 1; m_wcnt = 0; end
      else m_wcnt++;
    end else m_wcnt = 0;
`endif
    m_state = nxt;
  endtask

  // Driver: apply one microinstruction, push its expected result, wait for the edge.
  task automatic step(input bit rst, input int mode, input bit iv, input int ss,
                      input int tgt, input int op, input bit m, input bit z,
                      input bit n);
    @(negedge clk);
    reset = rst; n_sel = mode[2:0]; inv = iv; s_sel = ss[1:0]; cr = tgt[6:0];
    opcode = op[5:0]; mfc = m; zero = z; neg = n;
    model_edge(rst, mode, iv, ss, tgt, op, m, z, n);
    exp_q.push_back({m_state[6:0], m_ill, m_to});
    @(posedge clk);
  endtask

  task automatic jump(input int tgt);
    step(1, 1, 0, 3, tgt, 0, 0, 0, 0);
  endtask

  task automatic incr();
    step(1, 2, 0, 3, 0, 0, 0, 0, 0);
  endtask

  // Monitor / scoreboard
  initial begin
    logic [W-1:0] e;
    logic [W-1:0] a;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        a = {state, illegal_op, timeout};
        checks++;
        if (a !== e) begin
          errors++;
          $display("FAIL %s: state=%0d illegal_op=%b timeout=%b, expected state=%0d illegal_op=%b timeout=%b",
                   phase, a[8:2], a[1], a[0], e[8:2], e[1], e[0]);
        end
      end
    end
  end

  // Stimulus
  initial begin
    reset = 0; opcode = 0; mfc = 0; zero = 0; neg = 0; inv = 0;
    n_sel = 0; s_sel = 0; cr = 0;

    phase = "reset";
    step(0, 2, 0, 0, 0, 0, 0, 0, 0);
    jump(9);
    step(0, 1, 0, 3, 50, 0, 0, 0, 0);
    step(0, 1, 0, 3, 50, 0, 0, 0, 0);
    phase = "post_reset_inc";
    incr(); incr();

    phase = "dispatch_lw";
    step(1, 0, 0, 0, 0, 6'b100011, 0, 0, 0);
    phase = "dispatch_illegal";
    step(1, 0, 0, 0, 0, 6'b111111, 0, 0, 0);
    phase = "illegal_sticky";
    repeat (10) incr();
    phase = "dispatch_table";
    step(1, 0, 0, 0, 0, 6'b000000, 0, 0, 0);
    step(1, 0, 0, 0, 0, 6'b101011, 0, 0, 0);
    step(1, 0, 0, 0, 0, 6'b000100, 0, 0, 0);
    step(1, 0, 0, 0, 0, 6'b001000, 0, 0, 0);
    step(0, 2, 0, 0, 0, 0, 0, 0, 0);

    phase = "branch_taken";
    jump(10);
    step(1, 3, 0, 1, 12, 0, 0, 1, 0);
    phase = "branch_inverted";
    jump(10);
    step(1, 3, 1, 1, 12, 0, 0, 1, 0);
    phase = "branch_const_never";
    step(1, 3, 1, 3, 99, 0, 0, 0, 0);

    phase = "wait_mfc";
    jump(3);
    repeat (4) step(1, 5, 0, 0, 0, 0, 0, 0, 0);
    step(1, 5, 0, 0, 0, 0, 1, 0, 0);

    phase = "call_return";
    jump(20);
    step(1, 6, 0, 0, 40, 0, 0, 0, 0);
    incr();
    step(1, 7, 0, 0, 0, 0, 0, 0, 0);
    phase = "wrap";
    jump(127);
    incr();
    phase = "return_no_call";
    step(0, 6, 0, 0, 33, 0, 0, 0, 0);
    step(1, 7, 0, 0, 0, 0, 0, 0, 0);
    phase = "call_self";
    jump(50);
    step(1, 6, 0, 0, 50, 0, 0, 0, 0);
    step(1, 7, 0, 0, 0, 0, 0, 0, 0);

    phase = "timeout";
    jump(30);
    repeat (16) step(1, 5, 0, 0, 0, 0, 0, 0, 0);
    repeat (3) step(1, 5, 1, 3, 0, 0, 0, 0, 0);

    phase = "random";
    for (int i = 0; i < 600; i++) begin
      int op;
      op = ($urandom_range(0, 1) == 0) ? legal_ops[$urandom_range(0, 4)]
                                       : int'($urandom_range(0, 63));
      step(($urandom_range(0, 40) != 0), int'($urandom_range(0, 7)),
           bit'($urandom_range(0, 1)), int'($urandom_range(0, 3)),
           int'($urandom_range(0, 127)), op,
           bit'($urandom_range(0, 1)), bit'($urandom_range(0, 1)),
           bit'($urandom_range(0, 1)));
    end

    repeat (3) @(posedge clk);
    #2;
    phase = "drain";
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d expected entries left, expected 0", exp_q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/microsequencer.md
# microsequencer

Next-state controller for the microprogrammed MIPS control unit. Holds the current microstate register and computes the next state each cycle. The next state comes from the 3-bit next-address mode field of the current microinstruction, opcode dispatch, datapath condition flags and the memory-complete handshake. Its `state` output drives the microstore address; the microstore's `n_sel`/`inv`/`s_sel`/`cr` fields return to this block combinationally.

## Interface
- `STATE_W`, 7: microstate width.
- `RESET_STATE`, 0: state loaded on reset.
- `ILLEGAL_STATE`, 5: dispatch target for unknown opcodes and timeouts.
- `TIMEOUT`, 15: max wait cycles on `mfc` (used only with the macro).

Ports:
- `clk`  in  1  rising-edge clock.
- `reset`  in  1  synchronous, active-low reset.
- `opcode`  in  6  IR[31:26], valid while `n_sel` selects dispatch.
- `mfc`  in  1  memory function complete from RAM.
- `zero`  in  1  ALU zero flag.
- `neg`  in  1  ALU sign flag.
- `n_sel`  in  3  next-address mode from microinstruction.
- `inv`  in  1  invert selected condition.
- `s_sel`  in  2  condition select: 00 `mfc`, 01 `zero`, 10 `neg`, 11 constant 1.
- `cr`  in  STATE_W  branch/call target.
- `state`  out  STATE_W  current microstate (microstore address).
- `illegal_op`  out  1  sticky flag, unknown opcode dispatched.
- `timeout`  out  1  sticky flag, `mfc` wait expired (macro only, else tied 0).

## Operation
- Condition: `c = sel(s_sel) ^ inv`.
- `inc = state + 1`, modulo 2^STATE_W. 127 wraps to 0.
- Next state by `n_sel`:
  - 000 dispatch: `encode(opcode)`.
  - 001 jump: `cr`.
  - 010 increment: `inc`.
  - 011 cond branch: `c ? cr : inc`.
  - 100 cond dispatch: `c ? cr : encode(opcode)`.
  - 101 wait: `c ? inc : state`.
  - 110 call: `ret <= inc`, next = `cr`.
  - 111 return: next = `ret`.
- Encoder mapping:
  - 000000 (R-type) → 6.
  - 100011 (lw) → 7.
  - 101011 (sw) → 9.
  - 000100 (beq) → 11.
  - 001000 (addi) → 12.
  - Any other opcode → `ILLEGAL_STATE` and sets `illegal_op`.
- Single-level return register `ret`:
  - A call overwrites it.
  - A return does not clear it.
  - A return after reset with no prior call goes to 0.
- `illegal_op` and `timeout` stay set until reset.

## Timing
- One microinstruction per cycle. `state` is registered, and the next state is computed combinationally from inputs sampled at the rising edge.
- Latency: input change → `state` update at the next edge.
- Wait mode (101): holds while `c=0`. If `mfc` rises in cycle k, `state` = `inc` after edge k.
- When `reset`=0 at an edge:
  - `state` = `RESET_STATE`, `ret` = 0, `illegal_op` = 0, `timeout` = 0, wait counter = 0.
  - Reset overrides every mode, including a wait in progress or a call.
- Call and `ret` write happen on the same edge.
- Call with `cr` = current state is legal: `ret` = `inc`, state unchanged.
- `s_sel`=11 with `inv`=1 gives `c=0`:
  - Mode 011 never branches.
  - Mode 101 holds forever (a timeout breaks it only when the macro is enabled).
- An illegal dispatch sets `illegal_op` on the same edge that `state` becomes `ILLEGAL_STATE`.

## Configuration
- `MICROSEQ_TIMEOUT_EN` defined:
  - A 4-bit wait counter increments each cycle in which mode 101 holds (`c=0`).
  - It clears whenever mode 101 advances or any other mode executes.
  - When the counter reaches `TIMEOUT` while still holding, the next state is `ILLEGAL_STATE`, `timeout` is set, and the counter clears.
- Undefined: no counter, `timeout` constant 0, and wait mode holds indefinitely.

## Test plan
- Reset: `reset`=0 for 2 cycles from `state`=9 → `state`=0 and all flags 0. After release, mode 010 steps 0→1→2.
- Dispatch: `n_sel`=000 with `opcode`=100011 → 7. With `opcode`=111111 → 5 and `illegal_op`=1, which persists across 10 cycles.
- Branch: `n_sel`=011, `s_sel`=01, `cr`=12 from state 10:
  - `zero`=1, `inv`=0 → 12.
  - `zero`=1, `inv`=1 → 11.
- Wait handshake: `n_sel`=101, `s_sel`=00 at state 3. `mfc` low 4 cycles, then high → `state` stays 3 for 4 edges, then 4.
- Call/return: call at state 20 with `cr`=40 → 40. Mode 010 → 41. Return → 21. Increment from 127 → 0.
- Timeout (macro on): mode 101 with `mfc`=0 held for 16 cycles → `state`=5 and `timeout`=1. With the macro off, the same stimulus leaves `state` unchanged.
